// File: rtl/uart_line_loader.sv
// Host command parser feeding framebuffer RAM port A: 'L' + two row digits + 128 payload
// bytes loads one row, 'Z' clears all 4096 bytes; one registered byte write per cycle.
module uart_line_loader #(
    parameter int TIMEOUT_WIDTH = 24,
    parameter int TIMEOUT_TICKS = 1330000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [11:0] ram_address,
    output logic [7:0]  ram_data_out,
    output logic        ram_write_enable,
    output logic        ram_clk_enable,
    output logic        busy,
    output logic        line_done,
    output logic        clear_done,
    output logic        cmd_error
);

    typedef enum logic [2:0] {
        IDLE,
        ROW_HI,
        ROW_LO,
        PAYLOAD,
        CLEAR
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_TICKS - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_ONE  = TIMEOUT_WIDTH'(1);

    state_t                   state_q;
    logic [1:0]               tens_q;
    logic [4:0]               row_q;
    logic [6:0]               count_q;
    logic [11:0]              clear_q;
    logic [TIMEOUT_WIDTH-1:0] idle_q;
    logic [11:0]              addr_q;
    logic [7:0]               data_q;
    logic                     we_q;
    logic                     busy_q;
    logic                     line_done_q;
    logic                     clear_done_q;
    logic                     err_q;

    logic [5:0] row_d;
    logic       tens_ok;
    logic       units_ok;
    logic       timeout_hit;

    always_comb begin
        row_d       = ({4'd0, tens_q} * 6'd10) + {2'd0, rx_data[3:0]};
        tens_ok     = (rx_data >= 8'h30) && (rx_data <= 8'h33);
        units_ok    = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        timeout_hit = (idle_q == TIMEOUT_LAST);
    end

    // Idle counter only runs while a command is half-received; a byte always beats a timeout.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            tens_q       <= '0;
            row_q        <= '0;
            count_q      <= '0;
            clear_q      <= '0;
            idle_q       <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            line_done_q  <= 1'b0;
            clear_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            we_q         <= 1'b0;
            line_done_q  <= 1'b0;
            clear_done_q <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= (state_q != IDLE);

            if (state_q == IDLE || state_q == CLEAR || rx_valid || timeout_hit)
                idle_q <= '0;
            else
                idle_q <= idle_q + TIMEOUT_ONE;

            case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == 8'h4C) begin
                            state_q <= ROW_HI;
                        end else if (rx_data == 8'h5A) begin
                            clear_q <= '0;
                            state_q <= CLEAR;
                        end
                    end
                end
                ROW_HI: begin
                    if (rx_valid) begin
                        if (tens_ok) begin
                            tens_q  <= rx_data[1:0];
                            state_q <= ROW_LO;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                ROW_LO: begin
                    if (rx_valid) begin
                        if (units_ok && row_d <= 6'd31) begin
                            row_q   <= row_d[4:0];
                            count_q <= '0;
                            state_q <= PAYLOAD;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                PAYLOAD: begin
                    if (rx_valid) begin
                        addr_q  <= {row_q, count_q};
                        data_q  <= rx_data;
                        we_q    <= 1'b1;
                        count_q <= count_q + 7'd1;
                        if (count_q == 7'd127) begin
                            line_done_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                CLEAR: begin
                    addr_q  <= clear_q;
                    data_q  <= 8'h00;
                    we_q    <= 1'b1;
                    clear_q <= clear_q + 12'd1;
                    if (rx_valid)
                        err_q <= 1'b1;
                    if (clear_q == 12'hFFF) begin
                        clear_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_address      = addr_q;
    assign ram_data_out     = data_q;
    assign ram_write_enable = we_q;
    assign ram_clk_enable   = we_q;
    assign busy             = busy_q;
    assign line_done        = line_done_q;
    assign clear_done       = clear_done_q;
    assign cmd_error        = err_q;

endmodule

// File: tb/tb_uart_line_loader.sv
// Randomized self-checking bench for uart_line_loader: expected RAM writes, pulses and
// timing are derived from the command rules and compared with a negedge write log.
module tb_uart_line_loader;

    localparam int TICKS = 100;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [11:0] ram_address;
    logic [7:0]  ram_data_out;
    logic        ram_write_enable;
    logic        ram_clk_enable;
    logic        busy;
    logic        line_done;
    logic        clear_done;
    logic        cmd_error;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    int wrAddr[$];
    int wrData[$];
    int wrCyc[$];
    int lineDoneCyc[$];
    int clearDoneCyc[$];
    int errCyc[$];
    bit busyAt[int];

    uart_line_loader #(
        .TIMEOUT_WIDTH(24),
        .TIMEOUT_TICKS(TICKS)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .ram_address(ram_address),
        .ram_data_out(ram_data_out),
        .ram_write_enable(ram_write_enable),
        .ram_clk_enable(ram_clk_enable),
        .busy(busy),
        .line_done(line_done),
        .clear_done(clear_done),
        .cmd_error(cmd_error)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Log every observable event with the cycle it was seen in.
    always @(negedge clk_in) begin
        busyAt[cyc] = busy;
        if (ram_write_enable === 1'b1) begin
            wrAddr.push_back(int'(ram_address));
            wrData.push_back(int'(ram_data_out));
            wrCyc.push_back(cyc);
        end
        if (line_done === 1'b1) lineDoneCyc.push_back(cyc);
        if (clear_done === 1'b1) clearDoneCyc.push_back(cyc);
        if (cmd_error === 1'b1) errCyc.push_back(cyc);
        vectors++;
        if (ram_clk_enable !== ram_write_enable) begin
            miscompares++;
            $display("[TB] FAIL clk_enable_mirror cyc=%0d got %b want %b", cyc, ram_clk_enable, ram_write_enable);
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog simulation did not finish got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clearLogs();
        wrAddr.delete();
        wrData.delete();
        wrCyc.delete();
        lineDoneCyc.delete();
        clearDoneCyc.delete();
        errCyc.delete();
    endtask

    // Present one byte; sc is the cycle number of the edge that samples it.
    task automatic applyStimulus(input logic [7:0] b, output int sc);
        @(posedge clk_in);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        sc       = cyc + 1;
    endtask

    task automatic releaseBus();
        @(posedge clk_in);
        #1;
        rx_valid = 1'b0;
    endtask

    // Byte followed by exactly 'gap' idle sampled cycles.
    task automatic sendGap(input logic [7:0] b, input int gap, output int sc);
        applyStimulus(b, sc);
        if (gap > 0) begin
            releaseBus();
            repeat (gap - 1) @(posedge clk_in);
        end
    endtask

    task automatic test_reset();
        int sc;
        int busyHigh;
        int startCyc;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        clearLogs();
        startCyc = cyc;
        for (int i = 0; i < 20; i++) begin
            sendGap((i % 3 == 0) ? 8'h5A : ((i % 3 == 1) ? 8'h4C : 8'($urandom_range(255, 0))), 1, sc);
        end
        releaseBus();
        @(negedge clk_in);
        busyHigh = 0;
        for (int c = startCyc + 1; c <= cyc; c++)
            if (busyAt.exists(c) && busyAt[c]) busyHigh++;
        vectors++;
        if (wrAddr.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL reset_no_writes got %0d writes want 0", wrAddr.size());
        end
        vectors++;
        if (busyHigh !== 0) begin
            miscompares++;
            $display("[TB] FAIL reset_busy_low got %0d busy cycles want 0", busyHigh);
        end
        @(posedge clk_in);
        #1;
        reset = 1'b1;
        repeat (2) @(negedge clk_in);
        vectors++;
        if ({ram_write_enable, ram_clk_enable, busy, line_done, clear_done, cmd_error} !== 6'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_strobes got %b want 000000",
                     {ram_write_enable, ram_clk_enable, busy, line_done, clear_done, cmd_error});
        end
        vectors++;
        if ({ram_address, ram_data_out} !== 20'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_addr_data got %h/%h want 000/00", ram_address, ram_data_out);
        end
    endtask

    task automatic test_load_row(input string name, input int row, input logic [7:0] pay [128], input int maxGap);
        int lsc;
        int sc;
        int last;
        int bc [128];
        clearLogs();
        sendGap(8'h4C, 0, lsc);
        sendGap(8'(8'h30 + row / 10), 0, sc);
        sendGap(8'(8'h30 + row % 10), 0, sc);
        for (int i = 0; i < 128; i++) begin
            sendGap(pay[i], (i == 127) ? 0 : int'($urandom_range(maxGap, 0)), sc);
            bc[i] = sc;
        end
        releaseBus();
        repeat (3) @(negedge clk_in);
        last = bc[127];
        vectors++;
        if (wrAddr.size() !== 128) begin
            miscompares++;
            $display("[TB] FAIL %s write_count got %0d want 128", name, wrAddr.size());
        end else begin
            for (int i = 0; i < 128; i++) begin
                vectors++;
                if (wrAddr[i] !== row * 128 + i || wrData[i] !== int'(pay[i]) || wrCyc[i] !== bc[i]) begin
                    miscompares++;
                    $display("[TB] FAIL %s write[%0d] got addr %h data %h cyc %0d want addr %h data %h cyc %0d",
                             name, i, wrAddr[i], wrData[i], wrCyc[i], row * 128 + i, pay[i], bc[i]);
                end
            end
        end
        vectors++;
        if (lineDoneCyc.size() !== 1 || (lineDoneCyc.size() == 1 && lineDoneCyc[0] !== last)) begin
            miscompares++;
            $display("[TB] FAIL %s line_done got %0d pulses first at %0d want 1 pulse at %0d",
                     name, lineDoneCyc.size(), (lineDoneCyc.size() > 0) ? lineDoneCyc[0] : -1, last);
        end
        vectors++;
        if (busyAt[lsc + 1] !== 1'b1 || busyAt[last] !== 1'b1 || busyAt[last + 1] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s busy got rise=%b at_done=%b after=%b want 1 1 0",
                     name, busyAt[lsc + 1], busyAt[last], busyAt[last + 1]);
        end
        vectors++;
        if (errCyc.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL %s cmd_error got %0d pulses want 0", name, errCyc.size());
        end
    endtask

    task automatic test_rows();
        logic [7:0] pay [128];
        int row;
        for (int i = 0; i < 128; i++) pay[i] = 8'(i);
        test_load_row("row05_ramp", 5, pay, 0);
        for (int i = 0; i < 128; i++) pay[i] = 8'hFF;
        test_load_row("row31_ff", 31, pay, 0);
        for (int i = 0; i < 128; i++) pay[i] = 8'h4C;
        test_load_row("row00_L", 0, pay, 0);
        for (int n = 0; n < 3; n++) begin
            row = int'($urandom_range(31, 0));
            for (int i = 0; i < 128; i++) pay[i] = 8'($urandom_range(255, 0));
            test_load_row("row_random", row, pay, 3);
        end
    endtask

    task automatic test_errors();
        logic [7:0] seq [6][3];
        int len [6];
        int sc;
        logic [7:0] b;
        clearLogs();
        for (int i = 0; i < 10; i++) begin
            do b = 8'($urandom_range(255, 0)); while (b == 8'h4C || b == 8'h5A);
            sendGap(b, 0, sc);
        end
        releaseBus();
        repeat (2) @(negedge clk_in);
        vectors++;
        if (errCyc.size() !== 0 || wrAddr.size() !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_garbage got err=%0d writes=%0d busy=%b want 0 0 0",
                     errCyc.size(), wrAddr.size(), busy);
        end

        seq[0][0] = 8'h4C; seq[0][1] = 8'h33; seq[0][2] = 8'h35; len[0] = 3;
        seq[1][0] = 8'h4C; seq[1][1] = 8'h41; seq[1][2] = 8'h00; len[1] = 2;
        seq[2][0] = 8'h4C; seq[2][1] = 8'h33; seq[2][2] = 8'h32; len[2] = 3;
        seq[3][0] = 8'h4C; seq[3][1] = 8'(8'h30 + $urandom_range(3, 0));
        do b = 8'($urandom_range(255, 0)); while (b >= 8'h30 && b <= 8'h39);
        seq[3][2] = b; len[3] = 3;
        seq[4][0] = 8'h4C;
        do b = 8'($urandom_range(255, 0)); while (b >= 8'h30 && b <= 8'h33);
        seq[4][1] = b; seq[4][2] = 8'h00; len[4] = 2;
        seq[5][0] = 8'h4C; seq[5][1] = 8'h34; seq[5][2] = 8'h30; len[5] = 2;

        clearLogs();
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < len[k]; j++) sendGap(seq[k][j], 0, sc);
            releaseBus();
            repeat (2) @(negedge clk_in);
            vectors++;
            if (errCyc.size() !== k + 1 || (errCyc.size() == k + 1 && errCyc[k] !== sc)) begin
                miscompares++;
                $display("[TB] FAIL parse_error case %0d got %0d pulses last at %0d want %0d pulses last at %0d",
                         k, errCyc.size(), (errCyc.size() > 0) ? errCyc[errCyc.size() - 1] : -1, k + 1, sc);
            end
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL parse_error_idle case %0d got busy %b want 0", k, busy);
            end
        end
        vectors++;
        if (wrAddr.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL parse_error_writes got %0d want 0", wrAddr.size());
        end
    endtask

    task automatic test_timeout();
        logic [7:0] pay10 [10];
        logic [7:0] pay [128];
        int sc;
        int last;
        clearLogs();
        for (int i = 0; i < 10; i++) pay10[i] = 8'($urandom_range(255, 0));
        sendGap(8'h4C, 0, sc);
        sendGap(8'h31, 0, sc);
        sendGap(8'h32, 0, sc);
        for (int i = 0; i < 10; i++) sendGap(pay10[i], 0, sc);
        last = sc;
        releaseBus();
        for (int k = 0; k < 3 * TICKS && errCyc.size() == 0; k++) @(negedge clk_in);
        repeat (2) @(negedge clk_in);
        vectors++;
        if (errCyc.size() !== 1) begin
            miscompares++;
            $display("[TB] FAIL timeout_pulse got %0d pulses want 1", errCyc.size());
        end else begin
            vectors++;
            if (errCyc[0] < last + TICKS || errCyc[0] > last + TICKS + 1) begin
                miscompares++;
                $display("[TB] FAIL timeout_delay got %0d idle cycles want %0d", errCyc[0] - last, TICKS);
            end
        end
        vectors++;
        if (wrAddr.size() !== 10) begin
            miscompares++;
            $display("[TB] FAIL timeout_partial_count got %0d want 10", wrAddr.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                vectors++;
                if (wrAddr[i] !== 12'h600 + i || wrData[i] !== int'(pay10[i])) begin
                    miscompares++;
                    $display("[TB] FAIL timeout_partial[%0d] got %h/%h want %h/%h",
                             i, wrAddr[i], wrData[i], 12'h600 + i, pay10[i]);
                end
            end
        end
        vectors++;
        if (busy !== 1'b0 || lineDoneCyc.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL timeout_idle got busy %b line_done %0d want 0 0", busy, lineDoneCyc.size());
        end
        for (int i = 0; i < 128; i++) pay[i] = 8'($urandom_range(255, 0));
        test_load_row("row12_restart", 12, pay, 1);
    endtask

    task automatic test_clear();
        int zc;
        int inj [3];
        int bad;
        clearLogs();
        sendGap(8'h5A, 0, zc);
        releaseBus();
        repeat (100) @(posedge clk_in);
        sendGap(8'h4C, 0, inj[0]);
        releaseBus();
        repeat (1500) @(posedge clk_in);
        sendGap(8'h5A, 0, inj[1]);
        releaseBus();
        repeat (1500) @(posedge clk_in);
        sendGap(8'($urandom_range(255, 0)), 0, inj[2]);
        releaseBus();
        for (int k = 0; k < 6000 && clearDoneCyc.size() == 0; k++) @(negedge clk_in);
        repeat (2) @(negedge clk_in);
        vectors++;
        if (clearDoneCyc.size() !== 1 || (clearDoneCyc.size() == 1 && clearDoneCyc[0] !== zc + 4096)) begin
            miscompares++;
            $display("[TB] FAIL clear_done got %0d pulses first at %0d want 1 at %0d",
                     clearDoneCyc.size(), (clearDoneCyc.size() > 0) ? clearDoneCyc[0] : -1, zc + 4096);
        end
        vectors++;
        if (wrAddr.size() !== 4096) begin
            miscompares++;
            $display("[TB] FAIL clear_count got %0d want 4096", wrAddr.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 4096; i++) begin
                vectors++;
                if (wrAddr[i] !== i || wrData[i] !== 0 || wrCyc[i] !== zc + 1 + i) begin
                    miscompares++;
                    bad++;
                    if (bad <= 5)
                        $display("[TB] FAIL clear_write[%0d] got %h/%h cyc %0d want %h/00 cyc %0d",
                                 i, wrAddr[i], wrData[i], wrCyc[i], i, zc + 1 + i);
                end
            end
        end
        vectors++;
        if (errCyc.size() !== 3 || (errCyc.size() == 3 &&
            (errCyc[0] !== inj[0] || errCyc[1] !== inj[1] || errCyc[2] !== inj[2]))) begin
            miscompares++;
            $display("[TB] FAIL clear_dropped_bytes got %0d pulses want 3 at %0d %0d %0d",
                     errCyc.size(), inj[0], inj[1], inj[2]);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clear_idle got busy %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_clear();
        int zc;
        int n;
        logic [7:0] pay [128];
        clearLogs();
        sendGap(8'h5A, 0, zc);
        releaseBus();
        repeat (50) @(posedge clk_in);
        #3;
        reset = 1'b0;
        #1;
        vectors++;
        if (ram_write_enable !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_clear_immediate got we %b busy %b want 0 0", ram_write_enable, busy);
        end
        n = wrAddr.size();
        vectors++;
        if (n == 0 || wrAddr[n - 1] !== n - 1) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_clear_progress got %0d writes last %0d want >0 consecutive",
                     n, (n > 0) ? wrAddr[n - 1] : -1);
        end
        repeat (5) @(negedge clk_in);
        vectors++;
        if (wrAddr.size() !== n || clearDoneCyc.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_clear_halt got %0d writes want %0d", wrAddr.size(), n);
        end
        @(posedge clk_in);
        #1;
        reset = 1'b1;
        repeat (3) @(negedge clk_in);
        vectors++;
        if (wrAddr.size() !== n || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_clear_release got %0d writes busy %b want %0d 0", wrAddr.size(), busy, n);
        end
        for (int i = 0; i < 128; i++) pay[i] = 8'($urandom_range(255, 0));
        test_load_row("after_reset", int'($urandom_range(31, 0)), pay, 0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] pay [128];
        logic [7:0] pay2 [128];
        for (int i = 0; i < 128; i++) begin
            pay[i]  = 8'($urandom_range(255, 0));
            pay2[i] = 8'($urandom_range(255, 0));
        end
        test_load_row("b2b_first", 7, pay, 0);
        test_load_row("b2b_second", 30, pay2, 0);
    endtask

    initial begin
        test_reset();
        test_rows();
        test_errors();
        test_timeout();
        test_clear();
        test_reset_mid_clear();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
